// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for MIPS DIV/DIVU.
// Stalls the pipeline while iterating and strobes the HI/LO write once per result.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic             stall_req,
  output logic             o_valid,
  output logic             hilo_we,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_work;
  logic [WIDTH-1:0]   r_dsor;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_we;

  logic signed [WIDTH-1:0] w_op1_s;
  logic signed [WIDTH-1:0] w_op2_s;
  logic                    w_neg1;
  logic                    w_neg2;
  logic [WIDTH-1:0]        w_mag1;
  logic [WIDTH-1:0]        w_mag2;
  logic [WIDTH:0]          w_diff;
  logic [2*WIDTH-1:0]      w_step;
  logic                    w_accept;
  logic                    w_last;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign w_op1_s  = opdata1;
  assign w_op2_s  = opdata2;
  assign w_neg1   = signed_div && (w_op1_s < 0);
  assign w_neg2   = signed_div && (w_op2_s < 0);
  assign w_mag1   = cond_neg(opdata1, w_neg1);
  assign w_mag2   = cond_neg(opdata2, w_neg2);
  assign w_accept = (r_state == S_IDLE) && start && !annul;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // Shift-and-trial-subtract step; the partial remainder never exceeds the divisor,
  // so it fits in WIDTH bits once the shifted-in dividend bit is consumed.
  assign w_diff = r_work[2*WIDTH-1:WIDTH-1] - {1'b0, r_dsor};
  assign w_step = w_diff[WIDTH] ? {r_work[2*WIDTH-2:0], 1'b0}
                                : {w_diff[WIDTH-1:0], r_work[WIDTH-2:0], 1'b1};

  always_comb begin
    w_next    = r_state;
    stall_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !annul) begin
          stall_req = 1'b1;
          w_next    = (opdata2 == '0) ? S_BYZERO : S_BUSY;
        end
      end
      S_BYZERO: begin
        stall_req = 1'b1;
        w_next    = annul ? S_IDLE : S_DONE;
      end
      S_BUSY: begin
        stall_req = 1'b1;
        if (annul)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (annul || !start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_valid = (r_state == S_DONE);
  assign hilo_we = r_we;

  // Control state and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      o_hi    <= '0;
      o_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_we    <= (w_next == S_DONE) && (r_state != S_DONE);
      if (r_state == S_BUSY) r_cnt <= r_cnt + CNT_W'(1);
      else                   r_cnt <= '0;
      if (r_state == S_BYZERO && !annul) begin
        o_hi <= '0;
        o_lo <= '0;
      end else if (r_state == S_BUSY && w_last && !annul) begin
        o_hi <= cond_neg(w_step[2*WIDTH-1:WIDTH], r_neg_r);
        o_lo <= cond_neg(w_step[WIDTH-1:0], r_neg_q);
      end
    end
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work  <= {{WIDTH{1'b0}}, w_mag1};
      r_dsor  <= w_mag2;
      r_neg_r <= w_neg1;
      r_neg_q <= w_neg1 ^ w_neg2;
    end else if (r_state == S_BUSY) begin
      r_work <= w_step;
    end
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle sequencer for MIPS DIV/DIVU.
- Accepts operands from EX and runs a radix-2 restoring division over WIDTH cycles.
- Holds the pipeline with a stall request while it runs.
- Delivers the remainder/quotient pair with a one-cycle write strobe for the HI/LO register file (hi = remainder, lo = quotient).
- Sits between the EX stage, the stall controller and the HI/LO write port.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  division request from EX; held high until the result is consumed.
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
annul  input  1  cancel (flush/exception); aborts any division in progress.
opdata1  input  WIDTH  dividend.
opdata2  input  WIDTH  divisor.
stall_req  output  1  pipeline hold request.
o_valid  output  1  result valid.
hilo_we  output  1  HI/LO write strobe.
o_hi  output  WIDTH  remainder.
o_lo  output  WIDTH  quotient.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, counter=0, o_hi=0, o_lo=0, o_valid=0, hilo_we=0. Any in-flight division is discarded with no write.
- FSM states: IDLE, BYZERO, BUSY, DONE.
- IDLE:
  - If start=1 and annul=0: latch operands and signed_div.
  - Divisor==0 -> BYZERO.
  - Otherwise -> BUSY with counter=0.
  - start=1 with annul=1 is ignored.
- Signed mode:
  - Operands are latched as magnitudes; the sign flags are kept.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Division truncates toward zero.
- BUSY, one iteration per cycle:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor magnitude from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - counter increments each cycle. After iteration WIDTH-1 (WIDTH BUSY cycles), apply sign correction, register o_hi/o_lo, -> DONE.
- BYZERO: one cycle; result forced to hi=0, lo=0; -> DONE.
- DONE:
  - o_valid=1 for every cycle in DONE.
  - hilo_we=1 only on the first DONE cycle (registered pulse).
  - o_hi/o_lo hold stable.
  - Stay in DONE while start=1; -> IDLE on the first cycle start=0.
  - annul in DONE: -> IDLE; no second write.
- On leaving DONE, o_valid drops the next cycle; o_hi/o_lo retain their last values.
- stall_req (combinational) = (IDLE & start & ~annul) | BUSY | BYZERO. It is 0 in DONE, so the pipeline advances in the DONE cycle.
- annul in BUSY or BYZERO: -> IDLE next cycle; hilo_we stays 0; o_hi/o_lo unchanged; o_valid=0.
- Latency from start accepted in IDLE (cycle 0):
  - Nonzero divisor: BUSY cycles 1..WIDTH, DONE at cycle WIDTH+1 (33 for WIDTH=32).
  - Zero divisor: BYZERO at cycle 1, DONE at cycle 2.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Back-to-back: a new request is accepted only from IDLE, so start must drop for at least one cycle between divisions.
- Operand inputs are ignored after the IDLE acceptance cycle; changing them mid-operation has no effect.

Test Plan:
1. DIVU 100/7: start=1, signed_div=0 -> stall_req=1 cycles 0..32; DONE at cycle 33 with o_lo=14, o_hi=2; hilo_we pulses exactly one cycle; o_valid held until start drops.
2. DIV -7/2: opdata1=0xFFFFFFF9, opdata2=2 -> o_lo=0xFFFFFFFD (-3), o_hi=0xFFFFFFFF (-1). DIV 7/-2 -> o_lo=0xFFFFFFFD, o_hi=1.
3. Divide by zero: opdata2=0 -> BYZERO at cycle 1, DONE at cycle 2, o_hi=o_lo=0, hilo_we single pulse, stall_req=0 in DONE.
4. Annul at BUSY cycle 10 -> IDLE next cycle; hilo_we never asserts; o_hi/o_lo keep previous values; a subsequent DIVU 0xFFFFFFFF/0x10 completes correctly (lo=0x0FFFFFFF, hi=0xF).
5. rst=1 mid-BUSY -> next edge: state IDLE, all outputs 0, stall_req=0 while start=0. start held high through reset is re-accepted on the first post-reset cycle.
6. Signed overflow 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Same operands unsigned -> lo=0, hi=0x80000000. start held 5 extra cycles in DONE -> hilo_we stays 0 after the first pulse.
